qdr_rst_seq: RTL

Parametrised clock/reset/status sequencer for the multi-channel QDRII example design. It sits between the MMCM outputs and NUM_CH memory-controller instances. It qualifies MMCM lock with a debounce window and releases per-channel controller resets in a staggered order. It then supervises calibration with a timeout and bounded retry, and collects sticky per-channel compare errors for the status/LED logic.

---
 rtl/qdr_rst_seq_pkg.sv | 17 +
 rtl/qdr_sync2.sv | 19 +
 rtl/qdr_rst_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/qdr_rst_seq_pkg.sv
// qdr_rst_seq_pkg: state encodings and counter width helper for the QDR reset sequencer
package qdr_rst_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_STABLE    = 3'd1,
        S_RELEASE   = 3'd2,
        S_CAL_WAIT  = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/qdr_sync2.sv
// qdr_sync2: generic two-flop synchronizer with synchronous active-low clear
module qdr_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // two stages give the first flop a full cycle to resolve
    always_ff @(posedge clk) begin
        if (!rst_n) {q, meta} <= '0;
        else        {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/qdr_rst_seq.sv
// qdr_rst_seq: lock debounce, staggered channel reset release and calibration supervision
module qdr_rst_seq
    import qdr_rst_seq_pkg::*;
#(
    parameter int NUM_CH             = 2,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int RST_STAGGER        = 16,
    parameter int CAL_TIMEOUT_CYCLES = 1048576,
    parameter int MAX_RETRY          = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              locked,
    input  logic [NUM_CH-1:0] cal_done,
    input  logic [NUM_CH-1:0] compare_error,
    input  logic              err_clr,
    output logic [NUM_CH-1:0] mem_rst,
    output logic              all_cal_done,
    output logic              fail,
    output logic [NUM_CH-1:0] cal_timeout,
    output logic [NUM_CH-1:0] error_sticky,
    output logic [3:0]        retry_cnt,
    output logic [2:0]        state_o
);

    localparam int CW = cnt_w(LOCK_STABLE_CYCLES > RST_STAGGER ? LOCK_STABLE_CYCLES : RST_STAGGER);
    localparam int TW = cnt_w(CAL_TIMEOUT_CYCLES);
    localparam int IW = cnt_w(NUM_CH);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(RST_STAGGER - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(CAL_TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] CH_LAST   = IW'(NUM_CH - 1);
    localparam logic [3:0]    MAX_R     = 4'(MAX_RETRY);

    state_t            state, state_d;
    logic              lock_s;
    logic [CW-1:0]     cnt, cnt_d;
    logic [IW-1:0]     idx, idx_d;
    logic [TW-1:0]     timer, timer_d;
    logic [NUM_CH-1:0] mem_rst_d, cal_to_d, err_d;
    logic [3:0]        retry_d;
    logic              acd_d;

    qdr_sync2 #(.WIDTH(1)) u_lock_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (locked),
        .q     (lock_s)
    );

    assign state_o = state;
    assign fail    = (state == S_FAIL);

    // next-state, counters and status updates; lock loss takes priority over progress
    always_comb begin
        state_d   = state;
        cnt_d     = '0;
        idx_d     = idx;
        timer_d   = '0;
        mem_rst_d = mem_rst;
        retry_d   = retry_cnt;
        cal_to_d  = cal_timeout;
        case (state)
            S_WAIT_LOCK: state_d = lock_s ? S_STABLE : S_WAIT_LOCK;
            S_STABLE: begin
                if (!lock_s) state_d = S_WAIT_LOCK;
                else if (cnt == LOCK_LAST) begin
                    state_d = S_RELEASE;
                    idx_d   = '0;
                end else cnt_d = cnt + 1'b1;
            end
            S_RELEASE: begin
                if (!lock_s) state_d = S_WAIT_LOCK;
                else begin
                    if (cnt == '0) mem_rst_d = mem_rst & ~(NUM_CH'(1) << idx);
                    if (cnt != STAG_LAST) cnt_d = cnt + 1'b1;
                    else if (idx == CH_LAST) state_d = S_CAL_WAIT;
                    else idx_d = idx + 1'b1;
                end
            end
            S_CAL_WAIT: begin
                if (!lock_s) state_d = S_WAIT_LOCK;
                else if (&cal_done) state_d = S_RUN;
                else if (timer == TO_LAST) begin
                    cal_to_d = ~cal_done;
                    retry_d  = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 1'b1;
                    state_d  = (retry_cnt < MAX_R) ? S_WAIT_LOCK : S_FAIL;
                end else timer_d = timer + 1'b1;
            end
            S_RUN:   state_d = lock_s ? S_RUN : S_WAIT_LOCK;
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_WAIT_LOCK;
        endcase
        if (state_d == S_WAIT_LOCK || state_d == S_FAIL) mem_rst_d = '1;
        acd_d = lock_s && (state == S_CAL_WAIT || state == S_RUN) && (&cal_done);
        err_d = (error_sticky & ~{NUM_CH{err_clr}}) | (compare_error & cal_done & ~mem_rst);
    end

    // state and status registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= S_WAIT_LOCK;
            cnt          <= '0;
            idx          <= '0;
            timer        <= '0;
            mem_rst      <= '1;
            retry_cnt    <= '0;
            cal_timeout  <= '0;
            all_cal_done <= 1'b0;
            error_sticky <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            idx          <= idx_d;
            timer        <= timer_d;
            mem_rst      <= mem_rst_d;
            retry_cnt    <= retry_d;
            cal_timeout  <= cal_to_d;
            all_cal_done <= acd_d;
            error_sticky <= err_d;
        end
    end

endmodule
